// File: rtl/sysid_check_ctrl.sv
// rtl/sysid_check_ctrl.sv - Avalon-MM sysid reader that checks ID and timestamp against expected values
// Optional re-read on mismatch is enabled by defining SYSID_CHECK_RETRY_EN.
module sysid_check_ctrl #(
  parameter logic [31:0] EXPECTED_ID = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS = 32'h0000_0000,
  parameter int          AUTO_START  = 1,
  parameter int          TIMEOUT     = 255,
  parameter int          MAX_RETRY   = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        av_address,
  output logic        av_read,
  input  logic        av_waitrequest,
  input  logic [31:0] av_readdata,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [3:0]  attempts
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    RD_TS,
    CHECK,
    DONE
  } state_t;

`ifdef SYSID_CHECK_RETRY_EN
  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);
`else
  // A zero limit keeps attempts at 0, so any mismatch ends the check at once.
  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY) & 4'h0;
`endif

  // The stall that would make the counter reach TIMEOUT aborts the read.
  localparam logic [15:0] STALL_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] stall_cnt;
  logic        auto_pend;
  logic        go;
  logic        match;

  assign go    = start | auto_pend;
  assign match = (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      av_read    <= 1'b0;
      av_address <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      attempts   <= 4'd0;
      id_value   <= 32'd0;
      ts_value   <= 32'd0;
      stall_cnt  <= 16'd0;
      auto_pend  <= (AUTO_START != 0);
    end else begin
      auto_pend <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            state      <= RD_ID;
            av_read    <= 1'b1;
            av_address <= 1'b0;
            busy       <= 1'b1;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            attempts   <= 4'd0;
            stall_cnt  <= 16'd0;
          end
        end
        RD_ID, RD_TS: begin
          if (!av_waitrequest) begin
            stall_cnt <= 16'd0;
            if (state == RD_ID) begin
              id_value   <= av_readdata;
              av_address <= 1'b1;
              state      <= RD_TS;
            end else begin
              ts_value   <= av_readdata;
              av_read    <= 1'b0;
              av_address <= 1'b0;
              state      <= CHECK;
            end
          end else begin
            stall_cnt <= stall_cnt + 16'd1;
            if (stall_cnt == STALL_LAST) begin
              av_read    <= 1'b0;
              av_address <= 1'b0;
              timeout    <= 1'b1;
              pass       <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              state      <= DONE;
            end
          end
        end
        CHECK: begin
          if (match) begin
            pass  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (attempts != RETRY_LIMIT) begin
            attempts   <= attempts + 4'd1;
            av_read    <= 1'b1;
            av_address <= 1'b0;
            stall_cnt  <= 16'd0;
            state      <= RD_ID;
          end else begin
            pass  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sysid_check_ctrl.md
SYSID_CHECK_CTRL -- requirements
Module: sysid_check_ctrl

Interface
REQ-001 The block SHALL have parameter EXPECTED_ID, default 32'h0000_0000, meaning the value required at sysid word 0 (system ID).
REQ-002 The block SHALL have parameter EXPECTED_TS, default 32'h0000_0000, meaning the value required at sysid word 1 (timestamp).
REQ-003 The block SHALL have parameter AUTO_START, default 1, meaning one check runs automatically after reset release.
REQ-004 The block SHALL have parameter TIMEOUT, default 255, range 1..65535, meaning the maximum number of waitrequest cycles per read.
REQ-005 The block SHALL have parameter MAX_RETRY, default 3, range 0..15, meaning the number of re-reads allowed after a mismatch.
REQ-006 The block SHALL have port clock, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port reset_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-008 The block SHALL have port start, input, 1 bit, a single-cycle request to run a check.
REQ-009 The block SHALL have port av_address, output, 1 bit, the Avalon-MM master word address (0 = ID, 1 = timestamp).
REQ-010 The block SHALL have port av_read, output, 1 bit, the Avalon-MM read strobe.
REQ-011 The block SHALL have port av_waitrequest, input, 1 bit, the slave stall.
REQ-012 The block SHALL have port av_readdata, input, 32 bits, the read data, valid in the cycle in which av_read=1 and av_waitrequest=0.
REQ-013 The block SHALL have port id_value, output, 32 bits, the last captured ID.
REQ-014 The block SHALL have port ts_value, output, 32 bits, the last captured timestamp.
REQ-015 The block SHALL have port busy, done, pass and timeout, each output, 1 bit: busy = check in progress, done = single-cycle completion pulse, pass = result OK, timeout = read stalled too long.
REQ-016 The block SHALL have port attempts, output, 4 bits, the number of read passes in the last check minus 1.

Function
REQ-017 The FSM SHALL have the states IDLE, RD_ID, RD_TS, CHECK and DONE.
REQ-018 In IDLE, start=1 SHALL move the FSM to RD_ID next cycle, clear pass, timeout and attempts, and set busy.
REQ-019 In RD_ID, the block SHALL drive av_read=1 and av_address=0, stable until av_waitrequest=0; in that cycle it SHALL capture av_readdata into id_value and move to RD_TS.
REQ-020 In RD_TS, the block SHALL drive av_read=1 and av_address=1 under the same rule, capture into ts_value and move to CHECK.
REQ-021 av_read SHALL be 0 in IDLE, CHECK and DONE.
REQ-022 In CHECK, a match is (id_value==EXPECTED_ID && ts_value==EXPECTED_TS); on a match the block SHALL set pass=1 and move to DONE.
REQ-023 In DONE, done=1 for exactly one cycle and busy=0; the FSM SHALL then return to IDLE; pass, timeout, id_value, ts_value and attempts SHALL hold until the next start.
REQ-024 With av_waitrequest=0 throughout, start in cycle N SHALL give av_read in cycles N+1 and N+2 and done in cycle N+4.
REQ-025 A 16-bit stall counter SHALL clear on entry to each read state and increment on every cycle with av_read=1 and av_waitrequest=1.
REQ-026 When the stall counter reaches TIMEOUT, the block SHALL deassert av_read the next cycle, set timeout=1 and pass=0, and go to DONE without retry.
REQ-027 start while busy=1 or in DONE SHALL be ignored.
REQ-028 A grant (av_waitrequest=0) in the same cycle the counter reaches TIMEOUT SHALL count as success, and no timeout SHALL be flagged.

Reset
REQ-029 On reset_n=0, the block SHALL immediately force FSM=IDLE, av_read=0, av_address=0, busy=0, done=0, pass=0, timeout=0, attempts=0, id_value=0, ts_value=0 and stall counter=0, including mid-read.
REQ-030 If AUTO_START=1, the block SHALL behave as if start=1 in the first cycle after reset_n deasserts.

Configuration
REQ-031 With macro SYSID_CHECK_RETRY_EN defined, a mismatch in CHECK with attempts<MAX_RETRY SHALL increment attempts and return to RD_ID; with attempts==MAX_RETRY it SHALL go to DONE with pass=0.
REQ-032 With SYSID_CHECK_RETRY_EN undefined, a mismatch SHALL go directly to DONE with pass=0, and attempts SHALL be constant 0.

Verification
REQ-033 The bench SHALL cover: EXPECTED_ID=32'h1234_5678, EXPECTED_TS=32'h50A7_3ED9, slave returns those with zero waitrequest, start in cycle 10 -> av_read in cycles 11-12, done in cycle 14, pass=1, attempts=0.
REQ-034 The bench SHALL cover: av_waitrequest held 3 cycles on word 0 -> av_read and av_address=0 stable 4 cycles, id_value captured on the 4th, pass=1.
REQ-035 The bench SHALL cover: TIMEOUT=8, av_waitrequest stuck 1 -> av_read low after 8 stall cycles, done pulse, timeout=1, pass=0.
REQ-036 The bench SHALL cover: retry build, MAX_RETRY=3, ts mismatch on every read -> 4 read passes, done with pass=0, attempts=3; non-retry build -> 1 pass, attempts=0.
REQ-037 The bench SHALL cover: reset_n low during RD_TS -> av_read=0 in the same cycle, all outputs 0, AUTO_START=1 restarts the check after release.
REQ-038 The bench SHALL cover: start pulsed again while busy -> ignored, exactly one done pulse.
